// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM states and op-class helpers for the iterative MDU.
package mdu_pkg;
  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MADD  = 4'd5,
    OP_MADDU = 4'd6,
    OP_MSUB  = 4'd7,
    OP_MSUBU = 4'd8,
    OP_MTHI  = 4'd9,
    OP_MTLO  = 4'd10
  } op_e;

  typedef enum logic {IDLE, RUN} state_e;

  function automatic logic is_mult(input logic [3:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return op inside {OP_MULT, OP_MADD, OP_MSUB, OP_DIV};
  endfunction
endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: combinational restoring divider, signed or unsigned, with divide-by-zero flag.
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             dz
);
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] na, nb, q;
  logic [WIDTH:0]   r;
  assign neg_a = sgn & a[WIDTH-1];
  assign neg_b = sgn & b[WIDTH-1];
  assign na = neg_a ? -a : a;
  assign nb = neg_b ? -b : b;
  assign dz = b == '0;
  // Magnitudes are unsigned, so MIN / -1 wraps back to MIN with remainder 0.
  always_comb begin
    r = '0;
    q = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      r = {r[WIDTH-1:0], na[i]};
      if (r >= {1'b0, nb}) begin
        r = r - {1'b0, nb};
        q[i] = 1'b1;
      end
    end
  end
  assign quo = (neg_a ^ neg_b) ? -q : q;
  assign rem = neg_a ? -r[WIDTH-1:0] : r[WIDTH-1:0];
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: multicycle multiply/divide unit owning HI/LO, with accumulate, cancel and done pulse.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  state_e           state;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, quo, rem;
  logic             dz, sgn;
  logic [2*WIDTH-1:0] xa, xb, prod, acc, mres;
  assign busy = state == RUN;
  assign sgn  = is_signed_op(op_q);
  assign xa   = {{WIDTH{sgn & a_q[WIDTH-1]}}, a_q};
  assign xb   = {{WIDTH{sgn & b_q[WIDTH-1]}}, b_q};
  assign prod = xa * xb;
  assign acc  = {HI, LO};
  assign mres = op_q inside {OP_MADD, OP_MADDU} ? acc + prod :
                op_q inside {OP_MSUB, OP_MSUBU} ? acc - prod : prod;
  mdu_divider #(.WIDTH(WIDTH)) u_div (
    .a(a_q), .b(b_q), .sgn(sgn), .quo(quo), .rem(rem), .dz(dz)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start && !cancel) begin
          if (is_mult(op) || is_div(op)) begin
            state <= RUN;
            cnt   <= is_div(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            op_q  <= op;
            a_q   <= A;
            b_q   <= B;
          end else if (op == OP_MTHI) HI <= A;
          else if (op == OP_MTLO) LO <= A;
        end
      end else if (cancel) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (cnt == CW'(1)) begin
        state <= IDLE;
        cnt   <= '0;
        done  <= 1'b1;
        if (!is_div(op_q)) {HI, LO} <= mres;
        else if (!dz) {HI, LO} <= {rem, quo};
      end else cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed self-checking bench for mdu_iter with default parameters.
module tb_mdu_iter;
  import mdu_pkg::*;
  logic        clk = 0, reset = 1, start = 0, cancel = 0;
  logic [3:0]  op = 0;
  logic [31:0] A = 0, B = 0;
  logic        busy, done;
  logic [31:0] HI, LO;
  int errors = 0, checks = 0;

  mdu_iter dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .cancel(cancel), .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1; op = o; A = a; B = b;
    tick();
    start = 0; op = 0;
  endtask

  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int nb);
    issue(o, a, b);
    nb = 0;
    while (busy && nb < 50) begin
      nb++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (HI !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 0", HI); end
    checks++; if (LO !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 0", LO); end
    reset = 0;
  endtask

  task automatic test_mult();
    int nb;
    run_op(OP_MULT, 32'hFFFFFFFD, 32'd5, nb);
    checks++; if (nb !== 5) begin errors++; $display("FAIL mult_busy got %0d exp 5", nb); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mult_done got %b exp 1", done); end
    checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", HI); end
    checks++; if (LO !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_lo got %h exp fffffff1", LO); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_div();
    int nb;
    run_op(OP_DIVU, 32'd100, 32'd7, nb);
    checks++; if (nb !== 10) begin errors++; $display("FAIL divu_busy got %0d exp 10", nb); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL divu_done got %b exp 1", done); end
    checks++; if (LO !== 32'd14) begin errors++; $display("FAIL divu_lo got %h exp 0000000e", LO); end
    checks++; if (HI !== 32'd2) begin errors++; $display("FAIL divu_hi got %h exp 00000002", HI); end
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, nb);
    checks++; if (LO !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h exp fffffffd", LO); end
    checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h exp ffffffff", HI); end
  endtask

  task automatic test_accum();
    int nb;
    issue(OP_MTHI, 32'h0, 32'h0);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mthi_flags got busy=%b done=%b exp 0 0", busy, done); end
    checks++; if (HI !== 32'h0) begin errors++; $display("FAIL mthi_hi got %h exp 0", HI); end
    issue(OP_MTLO, 32'd10, 32'h0);
    checks++; if (LO !== 32'd10) begin errors++; $display("FAIL mtlo_lo got %h exp 0000000a", LO); end
    run_op(OP_MADDU, 32'hFFFFFFFF, 32'd2, nb);
    checks++; if (nb !== 5) begin errors++; $display("FAIL maddu_busy got %0d exp 5", nb); end
    checks++; if (HI !== 32'd2) begin errors++; $display("FAIL maddu_hi got %h exp 00000002", HI); end
    checks++; if (LO !== 32'd8) begin errors++; $display("FAIL maddu_lo got %h exp 00000008", LO); end
    run_op(OP_MSUB, 32'd1, 32'd1, nb);
    checks++; if (HI !== 32'd2) begin errors++; $display("FAIL msub_hi got %h exp 00000002", HI); end
    checks++; if (LO !== 32'd7) begin errors++; $display("FAIL msub_lo got %h exp 00000007", LO); end
  endtask

  task automatic test_divzero();
    int nb;
    issue(OP_MTHI, 32'h11, 32'h0);
    issue(OP_MTLO, 32'h22, 32'h0);
    run_op(OP_DIV, 32'd5, 32'd0, nb);
    checks++; if (nb !== 10) begin errors++; $display("FAIL dz_busy got %0d exp 10", nb); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL dz_done got %b exp 1", done); end
    checks++; if (HI !== 32'h11) begin errors++; $display("FAIL dz_hi got %h exp 00000011", HI); end
    checks++; if (LO !== 32'h22) begin errors++; $display("FAIL dz_lo got %h exp 00000022", LO); end
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, nb);
    checks++; if (LO !== 32'h80000000) begin errors++; $display("FAIL minneg1_lo got %h exp 80000000", LO); end
    checks++; if (HI !== 32'h0) begin errors++; $display("FAIL minneg1_hi got %h exp 0", HI); end
  endtask

  task automatic test_cancel();
    issue(OP_MTHI, 32'hA5, 32'h0);
    issue(OP_MTLO, 32'h5A, 32'h0);
    issue(OP_MULT, 32'd3, 32'd4);
    tick(); tick();
    cancel = 1;
    tick();
    cancel = 0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL cancel3_flags got busy=%b done=%b exp 0 0", busy, done); end
    tick();
    checks++; if (done !== 1'b0 || HI !== 32'hA5 || LO !== 32'h5A) begin errors++; $display("FAIL cancel3_hilo got done=%b %h %h exp 0 000000a5 0000005a", done, HI, LO); end
    issue(OP_MULT, 32'd3, 32'd4);
    tick(); tick(); tick(); tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cancel5_busy got %b exp 1", busy); end
    cancel = 1;
    tick();
    cancel = 0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL cancel5_flags got busy=%b done=%b exp 0 0", busy, done); end
    checks++; if (HI !== 32'hA5 || LO !== 32'h5A) begin errors++; $display("FAIL cancel5_hilo got %h %h exp 000000a5 0000005a", HI, LO); end
    cancel = 1;
    issue(OP_MULT, 32'd3, 32'd4);
    cancel = 0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_start got busy=%b exp 0", busy); end
    tick();
    checks++; if (done !== 1'b0 || HI !== 32'hA5) begin errors++; $display("FAIL cancel_start_hi got done=%b %h exp 0 000000a5", done, HI); end
  endtask

  task automatic test_reset_mid();
    issue(OP_DIV, 32'd50, 32'd3);
    tick(); tick();
    reset = 1;
    tick();
    reset = 0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_flags got busy=%b done=%b exp 0 0", busy, done); end
    checks++; if (HI !== 32'h0 || LO !== 32'h0) begin errors++; $display("FAIL rstmid_hilo got %h %h exp 0 0", HI, LO); end
    tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();
    checks++; if (done !== 1'b0 || LO !== 32'h0) begin errors++; $display("FAIL rstmid_late got done=%b lo=%h exp 0 0", done, LO); end
  endtask

  task automatic test_back_to_back();
    int nb;
    issue(OP_MULT, 32'd2, 32'd3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy1 got %b exp 1", busy); end
    tick();
    issue(OP_MULT, 32'd7, 32'd7);
    issue(OP_MTLO, 32'h55, 32'h0);
    checks++; if (busy !== 1'b1 || LO !== 32'h0) begin errors++; $display("FAIL b2b_busy4 got busy=%b lo=%h exp 1 0", busy, LO); end
    tick();
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_busy5 got busy=%b done=%b exp 1 0", busy, done); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL b2b_done got busy=%b done=%b exp 0 1", busy, done); end
    checks++; if (HI !== 32'h0 || LO !== 32'd6) begin errors++; $display("FAIL b2b_result got %h %h exp 0 00000006", HI, LO); end
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, nb);
    checks++; if (nb !== 5) begin errors++; $display("FAIL b2b_immediate_busy got %0d exp 5", nb); end
    checks++; if (HI !== 32'hFFFFFFFE || LO !== 32'h1) begin errors++; $display("FAIL b2b_multu got %h %h exp fffffffe 00000001", HI, LO); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_accum();
    test_divzero();
    test_cancel();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
